// File: rtl/ifbus_pkg.sv
// rtl/ifbus_pkg.sv - state codes, response codes and default tick counts for the I/F bus sequencer
package ifbus_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_STRB  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_REL   = 3'd5;

  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_OK   = 2'd1;
  localparam logic [1:0] RSP_EN   = 2'd2;
  localparam logic [1:0] RSP_PE   = 2'd3;

  localparam int DEF_SETTLE_TICKS  = 2;
  localparam int DEF_TIMEOUT_TICKS = 200;
  localparam int DEF_CNT_W         = 8;

  // Parity error outranks OK, which outranks EN.
  function automatic logic [1:0] resolve_rsp(input logic pe, input logic ok, input logic en);
    if (pe)
      return RSP_PE;
    else if (ok)
      return RSP_OK;
    else if (en)
      return RSP_EN;
    return RSP_NONE;
  endfunction

endpackage

// File: rtl/ifbus_seq_timer.sv
// rtl/ifbus_seq_timer.sv - loadable up/down counter shared by the settle and timeout phases
module ifbus_timer #(
  parameter int CNT_W = 8
) (
  input  logic             __clk,
  input  logic             __rst_,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge __clk) begin
    if (!__rst_)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (inc)
      cnt <= cnt + ONE;
    else if (dec)
      cnt <= cnt - ONE;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/ifbus_seq.sv
// rtl/ifbus_seq.sv - CPU-side I/F bus transfer sequencer; IFBUS_PARITY_EN enables parity-error handling
module ifbus_seq import ifbus_pkg::*; #(
  parameter int SETTLE_TICKS  = DEF_SETTLE_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic __clk,
  input  logic __rst_,
  input  logic req,
  input  logic wr,
  input  logic got,
  input  logic bus_free,
  input  logic ok_in,
  input  logic en_in,
  input  logic pe_in,
  output logic bus_req,
  output logic bus_drive,
  output logic bus_strobe,
  output logic bus_wr,
  output logic zw,
  output logic oken,
  output logic ok_out,
  output logic en_out,
  output logic alarm,
  output logic pe_flag
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

  logic [2:0]       state;
  logic [1:0]       rsp;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_inc;
  logic             tmr_dec;
  logic [CNT_W-1:0] tmr_cnt;
  logic             tmr_tc;

`ifdef IFBUS_PARITY_EN
  assign rsp = resolve_rsp(pe_in, ok_in, en_in);

  always_ff @(posedge __clk) begin
    if (!__rst_)
      pe_flag <= 1'b0;
    else if (state == S_IDLE && req)
      pe_flag <= 1'b0;
    else if (state == S_STRB && rsp == RSP_PE)
      pe_flag <= 1'b1;
  end
`else
  logic unused_pe;
  assign unused_pe = pe_in;
  assign rsp       = resolve_rsp(1'b0, ok_in, en_in);
  assign pe_flag   = 1'b0;
`endif

  // Settle phase counts down from SETTLE_TICKS-1; strobe phase counts up from 0.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_inc      = 1'b0;
    tmr_dec      = 1'b0;
    case (state)
      S_ARB: begin
        tmr_load     = req && bus_free;
        tmr_load_val = SETTLE_LOAD;
      end
      S_SETUP: begin
        tmr_load = tmr_tc;
        tmr_dec  = !tmr_tc;
      end
      S_STRB:  tmr_inc = 1'b1;
      default: ;
    endcase
  end

  ifbus_timer #(.CNT_W(CNT_W)) u_timer (
    .__clk    (__clk),
    .__rst_   (__rst_),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .inc      (tmr_inc),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .tc       (tmr_tc)
  );

  always_ff @(posedge __clk) begin
    if (!__rst_) begin
      state  <= S_IDLE;
      bus_wr <= 1'b0;
      ok_out <= 1'b0;
      en_out <= 1'b0;
      alarm  <= 1'b0;
    end else begin
      alarm <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          bus_wr <= wr;
          ok_out <= 1'b0;
          en_out <= 1'b0;
          state  <= S_ARB;
        end
        S_ARB:
          if (!req)
            state <= S_IDLE;
          else if (bus_free)
            state <= S_SETUP;
        S_SETUP: if (tmr_tc) state <= S_STRB;
        S_STRB: begin
          // A response arriving on the timeout cycle still counts as answered.
          case (rsp)
            RSP_PE: begin ok_out <= 1'b0; alarm <= 1'b1; state <= S_DONE; end
            RSP_OK: begin ok_out <= 1'b1; state <= S_DONE; end
            RSP_EN: begin en_out <= 1'b1; state <= S_DONE; end
            default: if (tmr_cnt == TIMEOUT_LAST) begin
              ok_out <= 1'b0;
              alarm  <= 1'b1;
              state  <= S_DONE;
            end
          endcase
        end
        S_DONE:  state <= S_REL;
        S_REL:   if (got) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus_req    = (state == S_ARB) || (state == S_SETUP) || (state == S_STRB) || (state == S_DONE);
  assign bus_drive  = (state == S_SETUP) || (state == S_STRB);
  assign bus_strobe = (state == S_STRB);
  assign zw         = (state != S_IDLE);
  assign oken       = (state == S_ARB) || (state == S_SETUP) || (state == S_STRB);

endmodule

// File: tb/tb_ifbus_seq.sv
// tb/tb_ifbus_seq.sv - directed bench for ifbus_seq; expectations follow IFBUS_PARITY_EN when defined
module tb_ifbus_seq;

  logic __clk = 1'b0;
  always #5 __clk = ~__clk;

  logic __rst_, req, wr, got, bus_free, ok_in, en_in, pe_in;
  logic bus_req, bus_drive, bus_strobe, bus_wr, zw, oken, ok_out, en_out, alarm, pe_flag;
  logic [9:0] outs;
  int total = 0;
  int bad   = 0;

  assign outs = {bus_req, bus_drive, bus_strobe, bus_wr, zw, oken, ok_out, en_out, alarm, pe_flag};

  ifbus_seq dut (
    .__clk(__clk), .__rst_(__rst_), .req(req), .wr(wr), .got(got), .bus_free(bus_free),
    .ok_in(ok_in), .en_in(en_in), .pe_in(pe_in), .bus_req(bus_req), .bus_drive(bus_drive),
    .bus_strobe(bus_strobe), .bus_wr(bus_wr), .zw(zw), .oken(oken), .ok_out(ok_out),
    .en_out(en_out), .alarm(alarm), .pe_flag(pe_flag)
  );

  task automatic step();
    @(negedge __clk);
  endtask

  task automatic to_strobe(output int n);
    n = 0;
    do begin step(); n++; end while (!bus_strobe && n < 20);
  endtask

  task automatic test_reset();
    __rst_ = 1'b0; req = 1'b0; wr = 1'b0; got = 1'b0; bus_free = 1'b0;
    ok_in = 1'b0; en_in = 1'b0; pe_in = 1'b0;
    step(); step();
    total++; if (outs !== 10'b0) begin bad++; $display("FAIL reset_outputs got=%b want=%b", outs, 10'b0); end
    __rst_ = 1'b1;
  endtask

  task automatic test_read_ok();
    int n, ns;
    logic drv_ok;
    wr = 1'b0; bus_free = 1'b1; req = 1'b1;
    to_strobe(n);
    req = 1'b0;
    total++; if (n !== 4) begin bad++; $display("FAIL read_to_strobe got=%0d want=4", n); end
    ns = 0; drv_ok = 1'b1;
    while (bus_strobe && ns < 10) begin
      ns++;
      if (!bus_drive) drv_ok = 1'b0;
      if (ns == 3) ok_in = 1'b1;
      step();
    end
    ok_in = 1'b0;
    total++; if (ns !== 3) begin bad++; $display("FAIL read_strobe_cycles got=%0d want=3", ns); end
    total++; if (drv_ok !== 1'b1) begin bad++; $display("FAIL read_strobe_without_drive got=%b want=1", drv_ok); end
    total++; if ({ok_out, en_out, oken, zw, alarm, bus_drive, bus_wr} !== 7'b1001000) begin
      bad++; $display("FAIL read_done got=%b want=%b", {ok_out, en_out, oken, zw, alarm, bus_drive, bus_wr}, 7'b1001000); end
    step();
    total++; if ({bus_req, zw} !== 2'b01) begin bad++; $display("FAIL read_rel got=%b want=01", {bus_req, zw}); end
    got = 1'b1; step(); got = 1'b0;
    total++; if ({zw, ok_out} !== 2'b01) begin bad++; $display("FAIL read_release got=%b want=01", {zw, ok_out}); end
  endtask

  task automatic test_write_wait();
    int arb, st;
    logic wr_ok;
    wr = 1'b1; bus_free = 1'b0; req = 1'b1;
    step();
    arb = 0; wr_ok = 1'b1;
    while (bus_req && !bus_drive && arb < 30) begin
      arb++;
      if (!bus_wr) wr_ok = 1'b0;
      if (arb == 10) bus_free = 1'b1;
      step();
    end
    total++; if (arb !== 10) begin bad++; $display("FAIL write_arb_cycles got=%0d want=10", arb); end
    st = 0;
    while (bus_drive && !bus_strobe && st < 10) begin
      st++;
      if (!bus_wr) wr_ok = 1'b0;
      step();
    end
    req = 1'b0;
    total++; if (st !== 2) begin bad++; $display("FAIL write_setup_cycles got=%0d want=2", st); end
    if (!bus_wr) wr_ok = 1'b0;
    ok_in = 1'b1; step(); ok_in = 1'b0;
    if (!bus_wr) wr_ok = 1'b0;
    total++; if ({ok_out, oken} !== 2'b10) begin bad++; $display("FAIL write_done got=%b want=10", {ok_out, oken}); end
    step();
    if (!bus_wr) wr_ok = 1'b0;
    got = 1'b1; step(); got = 1'b0;
    total++; if (wr_ok !== 1'b1) begin bad++; $display("FAIL write_bus_wr_held got=%b want=1", wr_ok); end
  endtask

  task automatic test_timeout(input logic answer_last);
    int n, ns;
    logic early;
    wr = 1'b0; bus_free = 1'b1; req = 1'b1;
    to_strobe(n);
    req = 1'b0;
    ns = 0; early = 1'b0;
    while (bus_strobe && ns < 300) begin
      ns++;
      if (alarm) early = 1'b1;
      if (answer_last && ns == 200) ok_in = 1'b1;
      step();
    end
    ok_in = 1'b0;
    total++; if (ns !== 200) begin bad++; $display("FAIL timeout_strobe_cycles got=%0d want=200", ns); end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL timeout_early_alarm got=%b want=0", early); end
    if (answer_last) begin
      total++; if ({alarm, ok_out, en_out, oken} !== 4'b0100) begin
        bad++; $display("FAIL coincident_ok got=%b want=0100", {alarm, ok_out, en_out, oken}); end
    end else begin
      total++; if ({alarm, ok_out, en_out, oken, bus_drive} !== 5'b10000) begin
        bad++; $display("FAIL timeout_done got=%b want=10000", {alarm, ok_out, en_out, oken, bus_drive}); end
    end
    step();
    total++; if ({alarm, bus_req, zw} !== 3'b001) begin bad++; $display("FAIL timeout_rel got=%b want=001", {alarm, bus_req, zw}); end
    got = 1'b1; step(); got = 1'b0;
    total++; if (zw !== 1'b0) begin bad++; $display("FAIL timeout_release got=%b want=0", zw); end
  endtask

  task automatic test_en_latency();
    int lat;
    wr = 1'b0; bus_free = 1'b1; req = 1'b1; en_in = 1'b1;
    lat = 0;
    do begin step(); lat++; end while (oken && lat < 20);
    en_in = 1'b0; req = 1'b0;
    total++; if (lat !== 5) begin bad++; $display("FAIL en_latency got=%0d want=5", lat); end
    total++; if ({ok_out, en_out, alarm} !== 3'b010) begin bad++; $display("FAIL en_only got=%b want=010", {ok_out, en_out, alarm}); end
    step(); got = 1'b1; step(); got = 1'b0;
  endtask

  task automatic test_abort();
    logic drv_seen;
    bus_free = 1'b0; req = 1'b1;
    step();
    drv_seen = bus_drive;
    total++; if ({zw, oken, bus_req, en_out} !== 4'b1110) begin
      bad++; $display("FAIL abort_arb got=%b want=1110", {zw, oken, bus_req, en_out}); end
    req = 1'b0; step();
    drv_seen = drv_seen | bus_drive;
    total++; if ({zw, oken, bus_req, drv_seen} !== 4'b0000) begin
      bad++; $display("FAIL abort_idle got=%b want=0000", {zw, oken, bus_req, drv_seen}); end
  endtask

  task automatic test_reset_mid();
    int n;
    wr = 1'b1; bus_free = 1'b1; req = 1'b1;
    to_strobe(n);
    req = 1'b0;
    total++; if (bus_strobe !== 1'b1) begin bad++; $display("FAIL mid_reach_strobe got=%b want=1", bus_strobe); end
    __rst_ = 1'b0; step();
    total++; if (outs !== 10'b0) begin bad++; $display("FAIL mid_reset_outputs got=%b want=%b", outs, 10'b0); end
    __rst_ = 1'b1; step();
    total++; if (outs !== 10'b0) begin bad++; $display("FAIL post_reset_outputs got=%b want=%b", outs, 10'b0); end
  endtask

  task automatic test_parity();
    int n;
    logic [2:0] exp;
`ifdef IFBUS_PARITY_EN
    exp = 3'b101;
`else
    exp = 3'b010;
`endif
    wr = 1'b0; bus_free = 1'b1; req = 1'b1;
    to_strobe(n);
    req = 1'b0; pe_in = 1'b1; ok_in = 1'b1;
    step();
    pe_in = 1'b0; ok_in = 1'b0;
    total++; if ({pe_flag, ok_out, alarm} !== exp) begin
      bad++; $display("FAIL parity_response got=%b want=%b", {pe_flag, ok_out, alarm}, exp); end
    step(); got = 1'b1; step(); got = 1'b0;
    bus_free = 1'b0; req = 1'b1; step(); req = 1'b0;
    total++; if ({pe_flag, ok_out} !== 2'b00) begin bad++; $display("FAIL parity_clear got=%b want=00", {pe_flag, ok_out}); end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    wr = 1'b0; bus_free = 1'b1; req = 1'b1;
    to_strobe(n);
    req = 1'b0; ok_in = 1'b1; step(); ok_in = 1'b0;
    step();
    got = 1'b1; req = 1'b1; step(); got = 1'b0;
    total++; if ({zw, oken} !== 2'b00) begin bad++; $display("FAIL b2b_idle_gap got=%b want=00", {zw, oken}); end
    step();
    total++; if ({zw, oken, ok_out} !== 3'b110) begin bad++; $display("FAIL b2b_second_accept got=%b want=110", {zw, oken, ok_out}); end
    req = 1'b0; step();
    total++; if (zw !== 1'b0) begin bad++; $display("FAIL b2b_abort got=%b want=0", zw); end
  endtask

  initial begin
    test_reset();
    test_read_ok();
    test_write_wait();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_en_latency();
    test_abort();
    test_reset_mid();
    test_parity();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifbus_seq.md
Name: ifbus_seq

Overview:
- Sequences one CPU-side I/F bus transfer per request: arbitrate, drive address/data, await the bus response (OK/EN), then release.
- Produces the zw/oken/ok$ signals consumed by the microcycle strobe generator.
- Strobes are held off (GOT/load-state blocked while zw & oken) until the transfer has completed or timed out.
- Sits between the CPU control decoder (request source) and the system I/F bus arbiter/drivers.

Parameters:
- SETTLE_TICKS, 2, clocks bus_drive is held before bus_strobe rises (address/data setup).
- TIMEOUT_TICKS, 200, clocks in S_STRB with no response before alarm; minimum 2.
- CNT_W, 8, counter width; must satisfy 2^CNT_W > max(SETTLE_TICKS, TIMEOUT_TICKS).

Ports:
- __clk  in  1  system clock, all logic on posedge
- __rst_  in  1  synchronous, active-low reset
- req  in  1  CPU requests an I/F transfer; sampled only in S_IDLE
- wr  in  1  1 = write, 0 = read; latched with req
- got  in  1  strobe generator in GOT state; release point
- bus_free  in  1  bus arbiter reports no other master holds the bus
- ok_in  in  1  bus response OK
- en_in  in  1  bus response EN (engaged/busy)
- pe_in  in  1  bus response parity error
- bus_req  out  1  request to bus arbiter
- bus_drive  out  1  enable CPU address/data drivers
- bus_strobe  out  1  transfer strobe (W or R line, per latched wr)
- bus_wr  out  1  latched direction
- zw  out  1  I/F claimed by CPU
- oken  out  1  transfer outstanding (not yet answered)
- ok_out  out  1  ok$ to strobe generator; 1 = last transfer answered OK
- en_out  out  1  last transfer answered EN
- alarm  out  1  timeout (no answer), one-cycle pulse
- pe_flag  out  1  parity error latched (see optional feature)

Behaviour:
- Reset: state S_IDLE; all outputs 0; counter 0. Reset mid-transfer drops bus_drive/bus_strobe on the same edge; no alarm is raised.
- State encoding lives in the package. States: S_IDLE, S_ARB, S_SETUP, S_STRB, S_DONE, S_REL.
- S_IDLE:
  - req=1 → latch wr into bus_wr, clear ok_out/en_out/pe_flag, go to S_ARB.
  - zw=1 and oken=1 from the next cycle.
- S_ARB:
  - bus_req=1. When bus_free=1 → S_SETUP and load counter with SETTLE_TICKS-1.
  - req dropping here aborts to S_IDLE (zw, oken → 0). req is ignored in every later state.
- S_SETUP:
  - bus_drive=1. Count down; at 0 → S_STRB and clear counter.
- S_STRB:
  - bus_drive=1, bus_strobe=1, counter increments.
  - Response priority: pe_in > ok_in > en_in.
  - ok_in → ok_out=1; en_in → en_out=1; either → S_DONE.
  - counter == TIMEOUT_TICKS-1 with no response → alarm pulse for 1 cycle, ok_out=0, → S_DONE.
  - A response on the same cycle as timeout wins; no alarm.
- S_DONE:
  - bus_strobe=0, bus_drive=0, oken=0 (zw stays 1). → S_REL next cycle.
- S_REL:
  - bus_req=0, zw=1. When got=1 → S_IDLE; zw=0 on the following cycle.
  - A req present on that same cycle is not taken until S_IDLE is entered; minimum 1 idle cycle between transfers.
- Latency:
  - bus_free already 1 and response on the first strobe cycle: req → oken falls in 3+SETTLE_TICKS clocks.
  - bus_strobe is never asserted without bus_drive. bus_drive is never asserted outside S_SETUP/S_STRB.
- ok_out/en_out/pe_flag hold their values until the next accepted req.

Optional Feature:
- Macro IFBUS_PARITY_EN.
- Defined: pe_in in S_STRB sets pe_flag=1, ok_out=0, pulses alarm, → S_DONE. It takes priority over ok_in/en_in.
- Undefined: pe_in is ignored entirely and pe_flag is tied to 0.

Decomposition:
- Package ifbus_pkg holds:
  - state localparams S_IDLE..S_REL (3-bit);
  - response codes RSP_NONE/RSP_OK/RSP_EN/RSP_PE;
  - default tick constants.
- One natural sub-module: ifbus_timer. It is the loadable down/up counter with terminal-count flag, shared by the settle and timeout phases.

Test Plan:
- Read, bus_free=1, ok_in on 3rd strobe cycle, SETTLE_TICKS=2 → bus_strobe high exactly 3 cycles; ok_out=1; oken falls 1 cycle after ok_in; zw falls 1 cycle after got=1.
- Write with bus_free=0 for 10 cycles → bus_req held 10 cycles; no bus_drive; then normal transfer with bus_wr=1 throughout.
- No response, TIMEOUT_TICKS=200 → alarm single pulse at strobe cycle 200; ok_out=0, en_out=0; bus released.
- ok_in and timeout coincident → ok_out=1, alarm=0. en_in alone → en_out=1, ok_out=0.
- req dropped in S_ARB → S_IDLE next cycle; zw=oken=0; bus_drive never asserted. __rst_=0 during S_STRB → all outputs 0 next edge.
- IFBUS_PARITY_EN defined, pe_in with ok_in → pe_flag=1, ok_out=0, alarm pulse. Undefined: same stimulus → ok_out=1, pe_flag=0.
